// File: rtl/dial_pkg.sv
// Shared types and constants for the rotary dial decoder.
// Quadrature states follow the Gray order 00 -> 01 -> 11 -> 10 -> 00 for clockwise rotation.
package dial_pkg;

    // Reset value for the per-channel debounce length: 20 us at 50 MHz.
    localparam int unsigned DefaultDebounceCycles = 1000;

    // Filtered {a, b} pair, with the enumerators named in clockwise order.
    typedef enum logic [1:0] {
        QuadS0 = 2'b00,
        QuadS1 = 2'b01,
        QuadS2 = 2'b11,
        QuadS3 = 2'b10
    } quad_state_e;

    // Sub-step result, stored as a two's complement value (+1 / 0 / -1).
    // The one spare code marks a jump of two positions, where both bits changed.
    typedef enum logic [1:0] {
        SubZero    = 2'b00,
        SubPlus    = 2'b01,
        SubIllegal = 2'b10,
        SubMinus   = 2'b11
    } substep_e;

    // Position of a state along the clockwise Gray sequence.
    function automatic logic [1:0] gray_index(input quad_state_e s);
        logic [1:0] idx;
        case (s)
            QuadS0:  idx = 2'd0;
            QuadS1:  idx = 2'd1;
            QuadS2:  idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Distance moved modulo 4: 1 is clockwise, 3 is counter-clockwise, and 2 is illegal.
    function automatic substep_e quad_decode(input quad_state_e prev, input quad_state_e cur);
        logic [1:0] diff;
        substep_e   sub;
        diff = gray_index(cur) - gray_index(prev);
        case (diff)
            2'd0:    sub = SubZero;
            2'd1:    sub = SubPlus;
            2'd3:    sub = SubMinus;
            default: sub = SubIllegal;
        endcase
        return sub;
    endfunction

endpackage

// File: rtl/dial_debounce.sv
// Debounce filter for one channel. The filtered level takes a new value only after the
// input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// DEBOUNCE_CYCLES must be at least 1.
module dial_debounce
    import dial_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    // Count the cycles in which the input differs from the filtered level.
    // When the input matches the filtered level again, the count goes back to 0.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (raw != filt_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Counter and filtered-level registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/rotary_dial_decoder.sv
// Quadrature rotary dial decoder. It produces an 8-bit wrapping position, a step pulse,
// the direction of the last step, and an error pulse on an illegal transition.
// Defining ROTARY_DIAL_DEBOUNCE_EN adds a debounce filter on each channel; without it,
// the synchroniser outputs are decoded directly.
// STEPS_PER_DETENT takes the values 1, 2 or 4.
module rotary_dial_decoder
    import dial_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DefaultDebounceCycles,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       clear,
    output logic [7:0] count,
    output logic       step,
    output logic       dir,
    output logic       error
);

    localparam logic signed [3:0] DetentPos = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] DetentNeg = -DetentPos;

    logic [1:0] sync_a_q, sync_b_q;
    logic       filt_a, filt_b;

    // Two-flop synchronisers on the asynchronous encoder inputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[0], quad_a};
            sync_b_q <= {sync_b_q[0], quad_b};
        end
    end

`ifdef ROTARY_DIAL_DEBOUNCE_EN
    dial_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_a (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .raw           (sync_a_q[1]),
        .filtered      (filt_a)
    );

    dial_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_b (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .raw           (sync_b_q[1]),
        .filtered      (filt_b)
    );
`else
    assign filt_a = sync_a_q[1];
    assign filt_b = sync_b_q[1];

    // The debounce length does nothing in this build.
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

    quad_state_e       cur_state;
    quad_state_e       prev_q, prev_d;
    logic              primed_q, primed_d;
    logic signed [3:0] acc_q, acc_d;
    logic signed [3:0] acc_sum;
    logic        [7:0] count_q, count_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              error_q, error_d;
    substep_e          sub;

    assign cur_state = quad_state_e'({filt_a, filt_b});

    // Decode each sub-step and update the accumulator, the position and the pulses.
    // The first cycle after reset only records the current state.
    always_comb begin
        prev_d   = cur_state;
        primed_d = 1'b1;
        acc_d    = acc_q;
        acc_sum  = acc_q;
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        error_d  = 1'b0;
        sub      = quad_decode(prev_q, cur_state);

        if (primed_q) begin
            unique case (sub)
                SubPlus:    acc_sum = acc_q + 4'sd1;
                SubMinus:   acc_sum = acc_q - 4'sd1;
                SubIllegal: begin
                    acc_sum = '0;
                    error_d = 1'b1;
                end
                default:    acc_sum = acc_q;
            endcase

            if (acc_sum == DetentPos) begin
                acc_sum = '0;
                count_d = count_q + 8'd1;
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end else if (acc_sum == DetentNeg) begin
                acc_sum = '0;
                count_d = count_q - 8'd1;
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end
            acc_d = acc_sum;
        end

        // Clear wins over a step in the same cycle and leaves the direction as it was.
        if (clear) begin
            count_d = '0;
            acc_d   = '0;
            step_d  = 1'b0;
            dir_d   = dir_q;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_q   <= QuadS0;
            primed_q <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            error_q  <= error_d;
        end
    end

    assign count = count_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign error = error_q;

endmodule

// File: tb/tb_rotary_dial_decoder.sv
// Self-checking bench for rotary_dial_decoder with STEPS_PER_DETENT = 4 and DEBOUNCE_CYCLES = 8.
// The reference model tracks the encoder as a position index 0..3 along the Gray cycle and
// counts sub-steps with plain arithmetic.
`timescale 1ns/1ps
module tb_rotary_dial_decoder;

    localparam int unsigned DebCycles = 8;
    localparam int          Spd       = 4;
`ifdef ROTARY_DIAL_DEBOUNCE_EN
    localparam int Lat = 3 + DebCycles;
`else
    localparam int Lat = 3;
`endif

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       quad_a        = 1'b0;
    logic       quad_b        = 1'b0;
    logic       clear         = 1'b0;
    logic [7:0] count;
    logic       step;
    logic       dir;
    logic       error;

    int checks = 0;
    int errors = 0;
    int step_seen = 0;
    int error_seen = 0;

    // Reference model state.
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int   m_pos   = 0;  // position the inputs are driven to
    int   m_prev  = 0;  // position the decoder last accepted
    int   m_acc   = 0;
    int   m_count = 0;
    logic m_dir   = 1'b1;
    int   m_steps = 0;
    int   m_errs  = 0;

    rotary_dial_decoder #(
        .DEBOUNCE_CYCLES  (DebCycles),
        .STEPS_PER_DETENT (Spd)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .quad_a        (quad_a),
        .quad_b        (quad_b),
        .clear         (clear),
        .count         (count),
        .step          (step),
        .dir           (dir),
        .error         (error)
    );

    always #5 clk_clk = ~clk_clk;

    // Count the cycles in which each pulse output is high.
    always @(posedge clk_clk) begin
        if (step === 1'b1) step_seen <= step_seen + 1;
        if (error === 1'b1) error_seen <= error_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Move the model from the accepted position to the driven position.
    task automatic model_settle();
        int d;
        d = (m_pos - m_prev + 4) % 4;
        m_prev = m_pos;
        if (d == 2) begin
            m_errs++;
            m_acc = 0;
        end else if (d == 1) begin
            m_acc++;
        end else if (d == 3) begin
            m_acc--;
        end
        if (m_acc == Spd) begin
            m_acc   = 0;
            m_count = (m_count + 1) % 256;
            m_dir   = 1'b1;
            m_steps++;
        end else if (m_acc == -Spd) begin
            m_acc   = 0;
            m_count = (m_count + 255) % 256;
            m_dir   = 1'b0;
            m_steps++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_dir"}, 32'(dir), 32'(m_dir));
        check({tag, "_steps"}, 32'(step_seen), 32'(m_steps));
        check({tag, "_errors"}, 32'(error_seen), 32'(m_errs));
    endtask

    task automatic drive_pos(input int d);
        m_pos = (m_pos + d) % 4;
        {quad_a, quad_b} = gray_tab[m_pos];
    endtask

    // Move by d positions (1 cw, 3 ccw, 2 illegal) and check once the move has settled.
    task automatic move(input int d, input string tag);
        @(negedge clk_clk);
        drive_pos(d);
        repeat (Lat + 2) @(negedge clk_clk);
        model_settle();
        check_state(tag);
    endtask

    // Same as move, but also check that the step pulse lands on the expected edge and lasts one cycle.
    task automatic move_timed(input int d, input string tag);
        int prior;
        @(negedge clk_clk);
        drive_pos(d);
        repeat (Lat - 1) @(negedge clk_clk);
        check({tag, "_step_early"}, 32'(step), 32'd0);
        @(negedge clk_clk);
        prior = m_steps;
        model_settle();
        check({tag, "_step_on_time"}, 32'(step), (m_steps != prior) ? 32'd1 : 32'd0);
        check({tag, "_count_on_time"}, 32'(count), 32'(m_count));
        @(negedge clk_clk);
        check({tag, "_step_width"}, 32'(step), 32'd0);
        check_state(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk_clk);
        clear = 1'b1;
        @(negedge clk_clk);
        clear = 1'b0;
        m_count = 0;
        m_acc   = 0;
        check(tag, 32'(count), 32'd0);
    endtask

    initial begin
        logic saved_dir;
        int   r;

        // Reset values while reset is held.
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        check_state("prime");

        // One clockwise detent, with the step timing checked on the last sub-step.
        move(1, "cw1");
        move(1, "cw2");
        move(1, "cw3");
        move_timed(1, "cw_detent");

        // Wrap down from 0 and back up.
        do_clear("clear0");
        repeat (3) move(3, "ccw");
        move_timed(3, "ccw_wrap");
        repeat (4) move(1, "cw_wrap");

        // An illegal jump, then legal clockwise sub-steps up to a detent.
        move(2, "illegal");
        move(1, "after_illegal");
        move(1, "post_ill2");
        move(1, "post_ill3");
        move(1, "post_ill4");

        // Clear lands on the same edge as a ccw detent completing at count 7.
        do_clear("clear1");
        repeat (28) move(1, "to7");
        check("at7", 32'(count), 32'd7);
        repeat (3) move(3, "ccw_pre");
        saved_dir = m_dir;
        @(negedge clk_clk);
        drive_pos(3);
        repeat (Lat - 1) @(negedge clk_clk);
        clear = 1'b1;
        @(negedge clk_clk);
        clear = 1'b0;
        model_settle();
        m_count = 0;
        m_acc   = 0;
        m_dir   = saved_dir;
        if (m_steps > 0) m_steps--;
        repeat (2) @(negedge clk_clk);
        check_state("clear_vs_step");

        // Reset partway through a detent leaves no partial step behind.
        repeat (3) move(1, "pre_rst");
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_dir", 32'(dir), 32'd1);
        repeat (2) @(negedge clk_clk);
        #2 reset_reset_n = 1'b1;
        m_prev  = 0;
        m_acc   = 0;
        m_count = 0;
        m_dir   = 1'b1;
        repeat (Lat + 3) @(negedge clk_clk);
        model_settle();
        check_state("post_rst");
        move(1, "post_rst_cw");

`ifdef ROTARY_DIAL_DEBOUNCE_EN
        // Glitches shorter than the debounce length are rejected.
        @(negedge clk_clk);
        quad_a = ~quad_a;
        repeat (5) @(negedge clk_clk);
        quad_a = ~quad_a;
        repeat (2 * Lat) @(negedge clk_clk);
        check_state("glitch5");
        quad_a = ~quad_a;
        repeat (DebCycles - 1) @(negedge clk_clk);
        quad_a = ~quad_a;
        repeat (2 * Lat) @(negedge clk_clk);
        check_state("glitch7");
        move_timed(1, "deb_accept");
`endif

        // Random walk, including illegal jumps and clears.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) do_clear("rnd_clear");
            else if (r < 15) move(2, "rnd_illegal");
            else if (r < 57) move(1, "rnd_cw");
            else move(3, "rnd_ccw");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotary_dial_decoder.md
ROTARY_DIAL_DECODER -- requirements
Module: rotary_dial_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000, input-stable clock count required before a level is accepted (20 us at 50 MHz).
REQ-002 SHALL have parameter STEPS_PER_DETENT, default 4, legal quadrature transitions per count change; legal values 1, 2, 4.
REQ-003 SHALL have port clk_clk  input  1  the single system clock; all state on rising edge.
REQ-004 SHALL have port reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port quad_a  input  1  encoder channel A, asynchronous to clk_clk.
REQ-006 SHALL have port quad_b  input  1  encoder channel B, asynchronous to clk_clk.
REQ-007 SHALL have port clear  input  1  synchronous zeroing of position.
REQ-008 SHALL have port count  output  8  dial position; drives the PIO dial input of the SoC.
REQ-009 SHALL have port step  output  1  one-cycle pulse when count changes.
REQ-010 SHALL have port dir  output  1  direction of last count change; 1 = up (clockwise), 0 = down.
REQ-011 SHALL have port error  output  1  one-cycle pulse on an illegal (both-bit) transition.

Function
REQ-012 SHALL pass each of quad_a, quad_b through a two-flop synchroniser before any other logic.
REQ-013 SHALL hold a filtered level per channel that adopts the synchronised level only after it has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the channel counter at 0.
REQ-014 SHALL decode the filtered pair {a,b} as Gray sequence 00->01->11->10->00 = +1 sub-step, reverse order = -1 sub-step, no change = 0.
REQ-015 SHALL treat a change of both filtered bits in one cycle as illegal: pulse error, clear the sub-step accumulator, leave count unchanged, adopt the new state as previous.
REQ-016 SHALL keep a signed sub-step accumulator; on reaching +STEPS_PER_DETENT: count+1, accumulator 0, dir=1, step pulse; on reaching -STEPS_PER_DETENT: count-1, accumulator 0, dir=0, step pulse.
REQ-017 SHALL wrap count modulo 256 (255+1=0, 0-1=255) with no saturation or flag.
REQ-018 SHALL, with debounce compiled out, update count and assert step on the third clk_clk rising edge after the edge that first samples the new input level; with debounce compiled in, DEBOUNCE_CYCLES edges later.
REQ-019 SHALL, when clear is high, set count=0 and accumulator=0 on that edge; clear overrides a coincident step and suppresses its step pulse; dir unchanged.
REQ-020 SHALL, after reset deassertion, capture the first filtered state as previous state without producing a sub-step (priming cycle).

Reset
REQ-021 SHALL, on reset_reset_n low, immediately force count=0, step=0, dir=1, error=0, accumulator=0, debounce counters=0, priming flag cleared, synchroniser and filtered flops to 0.
REQ-022 SHALL tolerate reset assertion mid-debounce or mid-detent with no residual partial step after release.

Configuration
REQ-023 SHALL compile the debounce filter only when macro ROTARY_DIAL_DEBOUNCE_EN is defined; when undefined, filtered level SHALL equal synchroniser output directly and DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-024 SHALL place quadrature state typedef (2-bit Gray enum), sub-step encoding (+1/0/-1) and default DEBOUNCE_CYCLES constant in shared package dial_pkg.
REQ-025 SHALL implement the per-channel debounce as sub-module dial_debounce, instantiated twice.

Verification
REQ-026 Debounce off, STEPS_PER_DETENT=4: four clockwise transitions 00->01->11->10->00 -> count 0->1, one step pulse, dir=1.
REQ-027 From count=0, one counter-clockwise detent -> count=255, step pulse, dir=0; from 255 one clockwise detent -> 0.
REQ-028 Filtered 00 jumps to 11 -> error pulse 1 cycle, count unchanged, accumulator 0; next legal 11->10 counts as +1 sub-step.
REQ-029 Debounce on, DEBOUNCE_CYCLES=8: 5-cycle glitch on quad_a -> no change; 8-cycle-stable level change -> accepted, sub-step registered.
REQ-030 clear asserted on the cycle a detent completes at count=7 -> count=0, no step pulse; reset asserted with accumulator=3 then released, one further +1 sub-step -> count stays 0.
